// File: rtl/shift_add_seq_if.sv
// Handshake and data bundle for the shift-add sequencer.
// The sequencer itself drives the slave side; a requester drives the master side.
interface shift_add_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] din;
    logic             sign_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic [3:0]       term_idx;

    modport master (
        output start,
        output abort,
        output din,
        output sign_in,
        input  busy,
        input  done,
        input  dout,
        input  term_idx
    );

    modport slave (
        input  start,
        input  abort,
        input  din,
        input  sign_in,
        output busy,
        output done,
        output dout,
        output term_idx
    );
endinterface

// File: rtl/shift_add_seq.sv
// Sequential shift-add: accumulates din >> k over a fixed 16-term schedule,
// one term per clock, then presents {~sign, acc[30:0]} with a one-cycle done.
module shift_add_seq #(
    parameter int WIDTH  = 32,
    parameter int NTERMS = 16
) (
    input  logic          clk,
    input  logic          rst,
    shift_add_seq_if.slave bus
);

    localparam int IW = $clog2(NTERMS);
    localparam logic [IW-1:0] LAST = IW'(NTERMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] din_q;
    logic [WIDTH-1:0] din_n;
    logic             sign_q;
    logic             sign_n;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_n;
    logic             done_q;
    logic             done_n;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_n;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] acc_sum;

    // Shift amount 32 is deliberate: it makes the last term contribute zero.
    function automatic logic [5:0] shift_of(input logic [IW-1:0] i);
        logic [5:0] k;
        case (i)
            4'd0:    k = 6'd2;
            4'd1:    k = 6'd4;
            4'd2:    k = 6'd5;
            4'd3:    k = 6'd7;
            4'd4:    k = 6'd9;
            4'd5:    k = 6'd13;
            4'd6:    k = 6'd15;
            4'd7:    k = 6'd18;
            4'd8:    k = 6'd19;
            4'd9:    k = 6'd20;
            4'd10:   k = 6'd22;
            4'd11:   k = 6'd24;
            4'd12:   k = 6'd25;
            4'd13:   k = 6'd27;
            4'd14:   k = 6'd28;
            default: k = 6'd32;
        endcase
        return k;
    endfunction

    assign term    = din_q >> shift_of(idx);
    assign acc_sum = acc + term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            din_q  <= '0;
            sign_q <= 1'b0;
            dout_q <= '0;
            done_q <= 1'b0;
            idx    <= '0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            din_q  <= din_n;
            sign_q <= sign_n;
            dout_q <= dout_n;
            done_q <= done_n;
            idx    <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        din_n   = din_q;
        sign_n  = sign_q;
        dout_n  = dout_q;
        done_n  = 1'b0;
        idx_n   = idx;
        unique case (state)
            IDLE: begin
                // start outranks abort here; abort only cancels a running job
                if (bus.start) begin
                    din_n   = bus.din;
                    sign_n  = bus.sign_in;
                    acc_n   = '0;
                    idx_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    idx_n   = '0;
                    state_n = IDLE;
                end else begin
                    acc_n = acc_sum;
                    if (idx == LAST) begin
                        dout_n  = {~sign_q, acc_sum[WIDTH-2:0]};
                        done_n  = 1'b1;
                        idx_n   = '0;
                        state_n = DONE;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.dout     = dout_q;
    assign bus.term_idx = idx;

endmodule

// File: tb/tb_shift_add_seq.sv
// Directed bench for shift_add_seq: vector table plus abort, reset
// and back-to-back start sequences.
module tb_shift_add_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    shift_add_seq_if bus ();

    shift_add_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] din;
        logic        sign;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    int sched[16] = '{2, 4, 5, 7, 9, 13, 15, 18, 19, 20, 22, 24, 25, 27, 28, 32};

    function automatic logic [31:0] ref_out(input logic [31:0] d, input logic s);
        logic [31:0] a;
        a = '0;
        for (int i = 0; i < 16; i++) a = a + (d >> sched[i]);
        return {~s, a[30:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input string nm, input logic [31:0] d,
                           input logic s, input logic [31:0] exp);
        int   cyc;
        logic busy_ok;
        @(negedge clk);
        bus.din     = d;
        bus.sign_in = s;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.din     = ~d;
        bus.sign_in = ~s;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!bus.done && cyc < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (!bus.busy) busy_ok = 1'b0;
        chk({nm, "_latency"}, 32'(cyc), 32'd17);
        chk({nm, "_busy"}, {31'd0, busy_ok}, 32'd1);
        chk({nm, "_dout"}, bus.dout, exp);
        chk({nm, "_idx_done"}, {28'd0, bus.term_idx}, 32'd0);
        @(negedge clk);
        chk({nm, "_done_clr"}, {31'd0, bus.done}, 32'd0);
        chk({nm, "_idle"}, {31'd0, bus.busy}, 32'd0);
        chk({nm, "_hold"}, bus.dout, exp);
    endtask

    task automatic wait_done(input string nm, input logic [31:0] exp);
        int cyc;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'd17);
        chk({nm, "_dout"}, bus.dout, exp);
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] q[$];
        int          last_acc;
        int          n;
        int          ndone;
        logic        seen;

        checks = 0;
        errors = 0;
        vecs[0] = '{"max_pos", 32'h7FFF_FFFF, 1'b0, 32'hAD45_3AC9};
        vecs[1] = '{"all_ones", 32'hFFFF_FFFF, 1'b0, 32'hDA8A_75A1};
        vecs[2] = '{"all_ones_neg", 32'hFFFF_FFFF, 1'b1, 32'h5A8A_75A1};
        vecs[3] = '{"zero_neg", 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[4] = '{"zero_pos", 32'h0000_0000, 1'b0, 32'h8000_0000};
        vecs[5] = '{"four_neg", 32'h0000_0004, 1'b1, 32'h0000_0001};
        vecs[6] = '{"msb_only", 32'h8000_0000, 1'b0, 32'hAD45_3AD8};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.din     = 32'hDEAD_BEEF;
        bus.sign_in = 1'b1;
        #12;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
        chk("rst_idx", {28'd0, bus.term_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i].nm, vecs[i].din, vecs[i].sign, vecs[i].exp);

        // abort at term 7, then start+abort together in IDLE
        @(negedge clk);
        bus.din     = 32'hFFFF_FFFF;
        bus.sign_in = 1'b0;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.term_idx != 4'd7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach7", {28'd0, bus.term_idx}, 32'd7);
        prev      = bus.dout;
        bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_dout", bus.dout, prev);
        bus.start   = 1'b1;
        bus.din     = 32'h0000_0004;
        bus.sign_in = 1'b1;
        @(negedge clk);
        chk("start_wins", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.din   = 32'hFFFF_FFFF;
        wait_done("after_abort", 32'h0000_0001);

        // asynchronous reset between edges mid-run
        @(negedge clk);
        bus.din     = 32'hFFFF_FFFF;
        bus.sign_in = 1'b0;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_dout", bus.dout, 32'd0);
        chk("arst_idx", {28'd0, bus.term_idx}, 32'd0);
        chk("arst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("arst_no_done", {31'd0, seen}, 32'd0);

        // first edge after reset release with start high is accepted
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        bus.start   = 1'b1;
        bus.din     = 32'h7FFF_FFFF;
        bus.sign_in = 1'b0;
        @(negedge clk);
        chk("post_rst_accept", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        wait_done("post_rst", 32'hAD45_3AC9);

        // start held high, din changing every cycle
        @(negedge clk);
        @(negedge clk);
        last_acc    = -1;
        ndone       = 0;
        bus.sign_in = 1'b0;
        bus.start   = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (q.size() > 0) chk("stream_dout", bus.dout, ref_out(q.pop_front(), 1'b0));
                else chk("stream_extra_done", 32'd1, 32'd0);
            end
            if (c >= 56) bus.start = 1'b0;
            bus.din = 32'h1357_9BDF + 32'(c) * 32'h0F1E_2D3C;
            if (!bus.busy && bus.start) begin
                if (last_acc >= 0) chk("stream_spacing", 32'(c - last_acc), 32'd18);
                last_acc = c;
                q.push_back(bus.din);
            end
        end
        chk("stream_count", 32'(ndone), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_add_seq.md
SHIFT_ADD_SEQ -- requirements
Module: shift_add_seq

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; this revision SHALL support only 32.
REQ-002 Parameter: NTERMS, 16, number of shift terms in the schedule; fixed at 16.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: start  input  1  request to begin one conversion; sampled only in IDLE.
REQ-006 Port: abort  input  1  synchronous cancel of a conversion in progress.
REQ-007 Port: din  input  32  operand, captured on the accepted start edge.
REQ-008 Port: sign_in  input  1  sign flag, captured with din.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: done  output  1  one-cycle pulse marking dout valid.
REQ-011 Port: dout  output  32  result {~sign_q, acc[30:0]}, held until the next completed conversion.
REQ-012 Port: term_idx  output  4  index of the schedule term being accumulated (debug).

Function
REQ-013 The block SHALL compute acc = sum of (din_q >> k) over k in the fixed schedule {2,4,5,7,9,13,15,18,19,20,22,24,25,27,28,32}, one term per clock, in that order.
REQ-014 Each shift SHALL be logical, zero-filling, on 32 bits; k=32 SHALL contribute 0.
REQ-015 Accumulation SHALL be 32-bit modulo 2^32 with no saturation and no carry-out.
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE with start=1: on that edge, capture din->din_q and sign_in->sign_q, clear acc and term_idx, and go to RUN.
REQ-018 RUN: on each edge, add term[term_idx] to acc and increment term_idx.
REQ-019 RUN with term_idx=15: on that edge, load dout with {~sign_q, final_acc[30:0]}, set done, go to DONE, and wrap term_idx to 0.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE with done cleared.
REQ-021 Latency: done SHALL be high in the cycle after the 16th edge following the start-accept edge, giving 17 cycles from accept to done.
REQ-022 start SHALL be ignored while busy=1, including in the DONE cycle, so the minimum start-to-start spacing is 18 cycles.
REQ-023 abort=1 in RUN SHALL force IDLE on that edge; done SHALL stay 0 and dout SHALL keep its previous value.
REQ-024 abort SHALL have no effect in IDLE or DONE.
REQ-025 In IDLE, if start and abort are both high, start SHALL win.
REQ-026 din and sign_in changing after the accept edge SHALL NOT affect the result.
REQ-027 term_idx SHALL read 0 in IDLE and DONE.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for a clock edge, force: state IDLE, busy 0, done 0, dout 0x0000_0000, term_idx 0, acc 0, din_q 0, sign_q 0.
REQ-029 Reset asserted mid-RUN SHALL discard the conversion, and no done pulse SHALL follow.
REQ-030 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-031 din=0x7FFF_FFFF, sign_in=0, one start pulse -> done exactly 17 cycles later, dout=0xAD45_3AC9; busy high for 17 cycles.
REQ-032 din=0xFFFF_FFFF, sign_in=0 -> dout=0xDA8A_75A1; repeat with sign_in=1 -> dout=0x5A8A_75A1.
REQ-033 Boundaries: din=0, sign_in=1 -> dout=0x0000_0000; din=0, sign_in=0 -> dout=0x8000_0000; din=4, sign_in=1 -> dout=0x0000_0001 (only the k=2 term is nonzero).
REQ-034 start held high continuously with din toggling every cycle -> conversions accepted every 18 cycles, each result matching din at its accept edge.
REQ-035 abort at term_idx=7 -> busy falls on the next edge, no done pulse, dout unchanged; a new start on the following cycle completes normally.
REQ-036 rst asserted asynchronously mid-RUN, between clock edges -> outputs go to reset values before the next edge and no done pulse follows.
